test_result_monitor: RTL and testbench
======================================

TEST_RESULT_MONITOR -- requirements
Module: test_result_monitor

Interface
REQ-001 Parameter FINISH_ADR, default 32'd252, byte address whose store ends a test program.
REQ-002 Parameter MAX_SCORE, default 32'd9, score value that counts as a full pass.
REQ-003 Parameter TIMEOUT_CYCLES, default 160, number of RUN cycles allowed before TIMEOUT.
REQ-004 Parameter HANG_CYCLES, default 8, number of consecutive cycles with an unchanged PC that counts as a hang.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mem_write  input  1  processor data-memory write strobe.
REQ-008 data_adr  input  32  processor data-memory address.
REQ-009 write_data  input  32  processor store data.
REQ-010 pc  input  32  processor program counter.
REQ-011 state  output  2  current monitor state (mon_state_t).
REQ-012 done  output  1  high while the state is DONE.
REQ-013 pass  output  1  high while done=1 and score==MAX_SCORE.
REQ-014 timeout  output  1  high while the state is TIMEOUT.
REQ-015 hang  output  1  high while the state is HANG.
REQ-016 score  output  32  write_data captured by the finishing store.
REQ-017 cycles  output  32  RUN-cycle count, frozen on entry to any terminal state.

Function
REQ-018 The states SHALL be RUN, DONE, TIMEOUT and HANG; DONE, TIMEOUT and HANG are terminal and are held until reset.
REQ-019 In RUN, a cycle with mem_write=1 and data_adr==FINISH_ADR SHALL move the state to DONE and capture write_data into score on that same edge.
REQ-020 mem_write cycles to any other address SHALL have no effect; stores made after a terminal state is reached SHALL be ignored, so the first finishing store wins.
REQ-021 cycles SHALL increment by 1 on every RUN edge, including the edge that leaves RUN, so cycles equals the number of RUN cycles elapsed.
REQ-022 In RUN, when cycles==TIMEOUT_CYCLES-1 and no finishing store occurs that cycle, the state SHALL move to TIMEOUT.
REQ-023 A hang counter SHALL increment while pc equals the previous cycle's registered pc and SHALL clear to 0 on any pc change.
REQ-024 When the hang counter reaches HANG_CYCLES-1 while the state is RUN, the state SHALL move to HANG.
REQ-025 When events coincide, priority SHALL be finishing store > HANG > TIMEOUT.
REQ-026 Counters SHALL saturate at their maximum value and never wrap.
REQ-027 Outputs SHALL be registered or decoded directly from state, with no combinational path from inputs to outputs.

Reset
REQ-028 Reset SHALL force state=RUN, score=0, cycles=0, the hang counter to 0 and the previous-pc register to 0, so done, pass, timeout and hang are all 0.
REQ-029 Reset asserted mid-run or in a terminal state SHALL take effect immediately; monitoring restarts on the first rising edge after reset deasserts.

Structure
REQ-030 Package test_monitor_pkg SHALL hold the mon_state_t enum (RUN=0, DONE=1, TIMEOUT=2, HANG=3) and the default constants FINISH_ADR, MAX_SCORE, TIMEOUT_CYCLES and HANG_CYCLES.
REQ-031 One sub-module, mon_sat_counter, SHALL provide a saturating counter with parameterized width, async reset, enable and synchronous clear; it is instantiated for both cycles and the hang counter.

Verification
REQ-032 Release reset, then in cycle 40 drive a store to 252 with write_data=9 -> state=DONE, score=9, pass=1, cycles=41.
REQ-033 Store to 252 with write_data=7, then a second store to 252 with write_data=9 -> score stays 7 and pass=0.
REQ-034 Increment pc by 4 every cycle with no finishing store -> timeout=1 after exactly 160 cycles, and cycles=160.
REQ-035 Hold pc=0x20 constant from cycle 10 -> hang=1 after 8 equal-pc cycles, with timeout=0.
REQ-036 Drive a finishing store on the same cycle that hang and timeout would fire -> state=DONE.
REQ-037 Assert reset while in DONE -> all outputs return to 0 immediately; a rerun to completion reproduces the REQ-032 result.

Source files
------------

// File: rtl/test_monitor_pkg.sv
// Shared types and default constants for the test-program result monitor.
package test_monitor_pkg;

    // Monitor state; RUN is the only non-terminal state.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DONE    = 2'd1,
        TIMEOUT = 2'd2,
        HANG    = 2'd3
    } mon_state_t;

    // Store to this byte address ends the test program.
    localparam logic [31:0] FINISH_ADR     = 32'd252;
    // Score reported by a fully passing program.
    localparam logic [31:0] MAX_SCORE      = 32'd9;
    // RUN cycles allowed before giving up.
    localparam int unsigned TIMEOUT_CYCLES = 160;
    // Consecutive equal-pc cycles treated as a hang.
    localparam int unsigned HANG_CYCLES    = 8;

endpackage

// File: rtl/test_result_monitor_sat_counter.sv
// Saturating up-counter: async reset, synchronous clear (wins over enable),
// holds at all-ones instead of wrapping.
module mon_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = '1;

    // Count enabled cycles, clear on request, stick at the maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/test_result_monitor.sv
// Watches a processor's store bus and program counter and reports how a
// test program ended: finishing store (DONE), run-time limit (TIMEOUT) or
// a stuck program counter (HANG). Terminal states hold until reset.
module test_result_monitor
    import test_monitor_pkg::*;
#(
    parameter logic [31:0] FINISH_ADR     = test_monitor_pkg::FINISH_ADR,
    parameter logic [31:0] MAX_SCORE      = test_monitor_pkg::MAX_SCORE,
    parameter int unsigned TIMEOUT_CYCLES = test_monitor_pkg::TIMEOUT_CYCLES,
    parameter int unsigned HANG_CYCLES    = test_monitor_pkg::HANG_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [31:0] write_data,
    input  logic [31:0] pc,
    output mon_state_t  state,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        hang,
    output logic [31:0] score,
    output logic [31:0] cycles
);

    localparam logic [31:0] TIME_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HANG_LAST = 32'(HANG_CYCLES - 1);

    mon_state_t  stateQ;
    logic [31:0] scoreQ;
    logic [31:0] cycleCnt;
    logic [31:0] hangCnt;
    logic [31:0] prevPc;

    logic finishStore;
    logic pcSame;
    logic inRun;
    logic hangHit;
    logic timeHit;

    assign finishStore = mem_write && (data_adr == FINISH_ADR);
    assign pcSame      = (pc == prevPc);
    assign inRun       = (stateQ == RUN);
    // Both limits look at registered counts, so the exit edge is the one
    // on which the count already sits at its last allowed value.
    assign hangHit     = (hangCnt == HANG_LAST);
    assign timeHit     = (cycleCnt == TIME_LAST);

    // RUN-cycle count; the edge leaving RUN still counts, then it freezes.
    mon_sat_counter #(.W(32)) uCycleCnt (
        .clk   (clk),
        .rst   (reset),
        .en    (inRun),
        .clr   (1'b0),
        .count (cycleCnt)
    );

    // Length of the current run of unchanged pc values.
    mon_sat_counter #(.W(32)) uHangCnt (
        .clk   (clk),
        .rst   (reset),
        .en    (pcSame),
        .clr   (!pcSame),
        .count (hangCnt)
    );

    // Remember last cycle's pc for the hang comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prevPc <= '0;
        end else begin
            prevPc <= pc;
        end
    end

    // Result FSM: finishing store beats hang, hang beats timeout; the
    // first finishing store latches the score and later stores are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= RUN;
            scoreQ <= '0;
        end else begin
            case (stateQ)
                RUN: begin
                    if (finishStore) begin
                        stateQ <= DONE;
                        scoreQ <= write_data;
                    end else if (hangHit) begin
                        stateQ <= HANG;
                    end else if (timeHit) begin
                        stateQ <= TIMEOUT;
                    end
                end
                default: stateQ <= stateQ;
            endcase
        end
    end

    // Status flags decode straight from registers; no input reaches an output.
    assign state   = stateQ;
    assign done    = (stateQ == DONE);
    assign pass    = (stateQ == DONE) && (scoreQ == MAX_SCORE);
    assign timeout = (stateQ == TIMEOUT);
    assign hang    = (stateQ == HANG);
    assign score   = scoreQ;
    assign cycles  = cycleCnt;

endmodule

// File: tb/tb_test_result_monitor.sv
// Bench for test_result_monitor: table of directed scenarios with hand-derived
// final results, a few timing-exact sequences, and random traffic checked
// every cycle against a history-based reference model.
module tb_test_result_monitor;
    import test_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic [31:0] pc;
    mon_state_t  state;
    logic        done, pass, timeout, hang;
    logic [31:0] score, cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test_result_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_adr   (data_adr),
        .write_data (write_data),
        .pc         (pc),
        .state      (state),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .hang       (hang),
        .score      (score),
        .cycles     (cycles)
    );

    typedef struct {
        int fin1;  int wd1;   // first store to the finish address (-1: none)
        int fin2;  int wd2;   // second store to the finish address
        int oth;              // store of 9 to address 248 (-1: none)
        int hold;             // cycle from which pc sticks at 0x20 (-1: never)
        int expSt; int expSc; int expCy;
    } vec_t;

    vec_t vecs[11];

    // Reference model: full pc history since reset plus outcome bookkeeping.
    int          mSt, mScore, mCyc;
    logic [31:0] pcHist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int st, input int sc, input int cy);
        chk({tag, ".state"},   32'(state),   32'(st));
        chk({tag, ".score"},   score,        32'(sc));
        chk({tag, ".cycles"},  cycles,       32'(cy));
        chk({tag, ".done"},    32'(done),    32'(st == 1));
        chk({tag, ".pass"},    32'(pass),    32'((st == 1) && (sc == 9)));
        chk({tag, ".timeout"}, 32'(timeout), 32'(st == 2));
        chk({tag, ".hang"},    32'(hang),    32'(st == 3));
    endtask

    function automatic int trailingEq();
        int n = 0;
        for (int i = pcHist.size() - 1; i > 0; i--) begin
            if (pcHist[i] == pcHist[i-1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic modelReset();
        mSt = 0; mScore = 0; mCyc = 0;
        pcHist = {};
        pcHist.push_back(32'd0);
    endtask

    task automatic modelStep(input bit mw, input logic [31:0] adr, input logic [31:0] wd,
                             input logic [31:0] p);
        if (mSt == 0) begin
            if (mw && adr == 32'd252) begin
                mSt = 1; mScore = int'(wd);
            end else if (trailingEq() >= 7) begin
                mSt = 3;
            end else if (mCyc == 159) begin
                mSt = 2;
            end
            mCyc++;
        end
        pcHist.push_back(p);
    endtask

    // Async reset; released mid-high-phase so the next rising edge is cycle 0.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; mem_write = 1'b0; data_adr = '0; write_data = '0; pc = '0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        modelReset();
    endtask

    // One cycle: inputs applied at the falling edge, outputs sampled 1 after rising.
    task automatic drive(input bit mw, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [31:0] p);
        @(negedge clk);
        mem_write = mw; data_adr = adr; write_data = wd; pc = p;
        @(posedge clk);
        #1;
    endtask

    task automatic vecInputs(input vec_t v, input int k, output bit mw,
                             output logic [31:0] adr, output logic [31:0] wd,
                             output logic [31:0] p);
        mw = 1'b0; adr = 32'd0; wd = 32'd0;
        p = (v.hold >= 0 && k >= v.hold) ? 32'h20 : 32'(4 * (k + 1));
        if (k == v.fin1)      begin mw = 1'b1; adr = 32'd252; wd = 32'(v.wd1); end
        else if (k == v.fin2) begin mw = 1'b1; adr = 32'd252; wd = 32'(v.wd2); end
        else if (k == v.oth)  begin mw = 1'b1; adr = 32'd248; wd = 32'd9; end
    endtask

    task automatic runVec(input vec_t v);
        bit mw; logic [31:0] adr, wd, p;
        for (int k = 0; k < 200; k++) begin
            vecInputs(v, k, mw, adr, wd, p);
            drive(mw, adr, wd, p);
        end
    endtask

    initial begin
        bit mw; logic [31:0] adr, wd, p, curPc;
        int mode;

        //        fin1 wd1 fin2 wd2 oth hold  st sc  cy
        vecs[0]  = '{ 40, 9, -1, 0, -1,  -1,  1, 9,  41};
        vecs[1]  = '{ 20, 7, 30, 9, -1,  -1,  1, 7,  21};
        vecs[2]  = '{ -1, 0, -1, 0, -1,  -1,  2, 0, 160};
        vecs[3]  = '{ -1, 0, -1, 0, -1,  10,  3, 0,  19};
        vecs[4]  = '{ 50, 3, -1, 0,  5,  -1,  1, 3,  51};
        vecs[5]  = '{159, 9, -1, 0, -1, 151,  1, 9, 160};
        vecs[6]  = '{ -1, 0, -1, 0, -1, 151,  3, 0, 160};
        vecs[7]  = '{  0, 9, -1, 0, -1,  -1,  1, 9,   1};
        vecs[8]  = '{159, 5, -1, 0, -1,  -1,  1, 5, 160};
        vecs[9]  = '{160, 9, -1, 0, -1,  -1,  2, 0, 160};
        vecs[10] = '{ -1, 0, -1, 0, -1, 152,  2, 0, 160};

        reset = 1'b1; mem_write = 1'b0; data_adr = '0; write_data = '0; pc = '0;
        #3;
        checkAll("reset", 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            doReset();
            runVec(vecs[i]);
            checkAll($sformatf("vec%0d", i), vecs[i].expSt, vecs[i].expSc, vecs[i].expCy);
        end

        // Hang fires on exactly the eighth equal-pc edge, not one earlier.
        doReset();
        for (int k = 0; k < 19; k++) begin
            vecInputs(vecs[3], k, mw, adr, wd, p);
            drive(mw, adr, wd, p);
            if (k == 17) checkAll("hangEdge17", 0, 0, 18);
            if (k == 18) checkAll("hangEdge18", 3, 0, 19);
        end

        // Reset while in DONE clears outputs without a clock edge; rerun matches.
        doReset();
        runVec(vecs[0]);
        #1 reset = 1'b1;
        #1 checkAll("rstInDone", 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        modelReset();
        runVec(vecs[0]);
        checkAll("rerun", 1, 9, 41);

        // Random traffic checked each cycle against the model.
        for (int s = 0; s < 24; s++) begin
            mode = s % 3;
            doReset();
            curPc = 32'h100;
            for (int k = 0; k < 175; k++) begin
                mw = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 3))
                    0: adr = (mode == 2) ? 32'd248 : 32'd252;
                    1: adr = 32'd248;
                    2: adr = 32'd256;
                    default: adr = $urandom;
                endcase
                if (mode == 0 && $urandom_range(0, 9) != 0 && adr == 32'd252) mw = 1'b0;
                wd = 32'($urandom_range(0, 12));
                if (mode == 1) begin
                    if ($urandom_range(0, 9) == 0) curPc = 32'($urandom_range(0, 3) * 4);
                end else begin
                    curPc = curPc + 32'd4;
                end
                drive(mw, adr, wd, curPc);
                modelStep(mw, adr, wd, curPc);
                checkAll($sformatf("rand%0d.%0d", s, k), mSt, mScore, mCyc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
